// File: rtl/mac_arb_pkg.sv
// Shared types and defaults for the round-robin mac sharing arbiter.
package mac_arb_pkg;

  localparam int unsigned OPSIZE_DEF = 16;
  localparam int unsigned NREQ_DEF   = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    WAIT_LOW,
    WAIT_HIGH,
    DONE
  } state_e;

endpackage

// File: rtl/mac_arbiter_if.sv
// Client-side and mac-side signal bundle for mac_arbiter.
interface mac_arbiter_if
  import mac_arb_pkg::*;
#(
  parameter int unsigned NREQ   = NREQ_DEF,
  parameter int unsigned OPSIZE = OPSIZE_DEF
);

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        term_valid;
  logic [NREQ-1:0]        term_last;
  logic [NREQ*OPSIZE-1:0] a_in;
  logic [NREQ*OPSIZE-1:0] b_in;
  logic [NREQ-1:0]        grant;
  logic [NREQ-1:0]        term_ack;
  logic [NREQ-1:0]        res_valid;
  logic [2*OPSIZE-1:0]    res;
  logic                   busy;
  logic                   mac_start;
  logic                   mac_reset;
  logic [OPSIZE-1:0]      mac_a;
  logic [OPSIZE-1:0]      mac_b;
  logic [2*OPSIZE-1:0]    mac_out;
  logic                   mac_ready;

  modport master (
    input  req, term_valid, term_last, a_in, b_in, mac_out, mac_ready,
    output grant, term_ack, res_valid, res, busy, mac_start, mac_reset, mac_a, mac_b
  );

  modport slave (
    output req, term_valid, term_last, a_in, b_in, mac_out, mac_ready,
    input  grant, term_ack, res_valid, res, busy, mac_start, mac_reset, mac_a, mac_b
  );

endinterface

// File: rtl/mac_arbiter_rr_pick.sv
// Combinational round-robin select: first set request strictly after ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt_c,
  output logic [IDW-1:0]  idx_c
);

  logic           found;
  logic [IDW-1:0] cand;

  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        gnt_c[cand] = 1'b1;
        idx_c       = cand;
      end
    end
  end

endmodule

// File: rtl/mac_arbiter.sv
// Round-robin sequencer sharing one start/ready mac among NREQ burst clients.
module mac_arbiter
  import mac_arb_pkg::*;
#(
  parameter int unsigned OPSIZE = OPSIZE_DEF,
  parameter int unsigned NREQ   = NREQ_DEF
) (
  input  logic          clk,
  input  logic          reset,
  mac_arbiter_if.master bus
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned RW  = 2 * OPSIZE;

  state_e            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d, owner_q, owner_d, pick_idx_c;
  logic [NREQ-1:0]   grant_q, grant_d, term_ack_q, term_ack_d, res_valid_q, res_valid_d;
  logic [NREQ-1:0]   pick_gnt_c;
  logic [RW-1:0]     res_q, res_d;
  logic [OPSIZE-1:0] mac_a_q, mac_a_d, mac_b_q, mac_b_d, sel_a_c, sel_b_c;
  logic              busy_q, mac_start_q, mac_start_d, mac_reset_q, mac_reset_d;
  logic              last_q, last_d;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_rr_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .gnt_c (pick_gnt_c),
    .idx_c (pick_idx_c)
  );

  // Operand lanes of the current owner
  always_comb begin
    sel_a_c = '0;
    sel_b_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner_q == IDW'(i)) begin
        sel_a_c = bus.a_in[i*OPSIZE +: OPSIZE];
        sel_b_c = bus.b_in[i*OPSIZE +: OPSIZE];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    term_ack_d  = '0;
    res_valid_d = '0;
    res_d       = res_q;
    mac_start_d = mac_start_q;
    mac_reset_d = 1'b0;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;
    last_d      = last_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          owner_d     = pick_idx_c;
          grant_d     = pick_gnt_c;
          mac_reset_d = 1'b1;
          state_d     = CLEAR;
        end
      end
      CLEAR: state_d = ISSUE;
      ISSUE: begin
        if (!bus.req[owner_q]) begin
          grant_d = '0;
          ptr_d   = owner_q;
          state_d = IDLE;
        end else if (bus.mac_ready && bus.term_valid[owner_q]) begin
          mac_a_d     = sel_a_c;
          mac_b_d     = sel_b_c;
          last_d      = bus.term_last[owner_q];
          term_ack_d  = grant_q;
          mac_start_d = 1'b1;
          state_d     = WAIT_LOW;
        end
      end
      // start held until the mac shows it has taken the term
      WAIT_LOW: begin
        if (!bus.mac_ready) begin
          mac_start_d = 1'b0;
          state_d     = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (bus.mac_ready) state_d = last_q ? DONE : ISSUE;
      end
      DONE: begin
        res_d       = bus.mac_out;
        res_valid_d = grant_q;
        grant_d     = '0;
        ptr_d       = owner_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= IDW'(NREQ - 1);
      owner_q     <= '0;
      grant_q     <= '0;
      term_ack_q  <= '0;
      res_valid_q <= '0;
      res_q       <= '0;
      busy_q      <= 1'b0;
      mac_start_q <= 1'b0;
      mac_reset_q <= 1'b1;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      term_ack_q  <= term_ack_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
      busy_q      <= (state_d != IDLE);
      mac_start_q <= mac_start_d;
      mac_reset_q <= mac_reset_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      last_q      <= last_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.term_ack  = term_ack_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res       = res_q;
  assign bus.busy      = busy_q;
  assign bus.mac_start = mac_start_q;
  assign bus.mac_reset = mac_reset_q;
  assign bus.mac_a     = mac_a_q;
  assign bus.mac_b     = mac_b_q;

endmodule

// File: tb/tb_mac_arbiter.sv
// Directed bench for mac_arbiter: behavioural mac plus autonomous burst clients.
module tb_mac_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_arbiter_if #(.NREQ(4), .OPSIZE(16)) bus ();

  mac_arbiter #(.OPSIZE(16), .NREQ(4)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // mac model: ready drops 1 cycle after start, rises 2 cycles later with a*b accumulated
  logic [31:0] acc;
  logic        rdy;
  int          mcnt;
  always @(posedge clk or posedge rst) begin
    if (rst || bus.mac_reset) begin
      acc <= '0; rdy <= 1'b1; mcnt <= 0;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        rdy <= 1'b1;
        acc <= acc + 32'(bus.mac_a) * 32'(bus.mac_b);
      end
    end else if (bus.mac_start && rdy) begin
      rdy <= 1'b0; mcnt <= 2;
    end
  end
  assign bus.mac_out   = acc;
  assign bus.mac_ready = rdy;

  // client configuration (written by the stimulus block only)
  int          nterm[4], abort_at[4], start_cnt[4];
  logic [15:0] av[4], bv[4];
  bit          tv_noreq[4];
  // client state (written by the client block only)
  int          sent[4], done_cnt[4], ack_cnt[4], rv_cnt[4], clr_cnt;
  logic [31:0] last_res[4];
  int          order_q[$];

  logic [3:0]  req_v, tv_v, last_v;
  logic [63:0] a_v, b_v;
  bit          pend;

  always @(negedge clk) begin
    if (!rst && bus.mac_reset && (bus.grant != 4'd0)) clr_cnt++;
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        sent[i] = 0; done_cnt[i] = start_cnt[i];
      end else begin
        if (bus.term_ack[i]) begin ack_cnt[i]++; sent[i]++; end
        if (bus.res_valid[i]) begin
          rv_cnt[i]++; last_res[i] = bus.res; done_cnt[i] = start_cnt[i]; sent[i] = 0;
          order_q.push_back(i);
        end
        if (abort_at[i] != 0 && sent[i] == abort_at[i] && start_cnt[i] != done_cnt[i]) begin
          done_cnt[i] = start_cnt[i]; sent[i] = 0;
        end
      end
      pend = (start_cnt[i] != done_cnt[i]);
      req_v[i]  = pend;
      tv_v[i]   = (pend && sent[i] < nterm[i]) || tv_noreq[i];
      last_v[i] = (sent[i] == nterm[i] - 1);
      a_v[i*16 +: 16] = av[i];
      b_v[i*16 +: 16] = bv[i];
    end
    bus.req = req_v; bus.term_valid = tv_v; bus.term_last = last_v;
    bus.a_in = a_v; bus.b_in = b_v;
  end

  function automatic bit all_done();
    for (int i = 0; i < 4; i++) if (start_cnt[i] != done_cnt[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic cfg(input int c, input int n, input logic [15:0] a, input logic [15:0] b);
    nterm[c] = n; av[c] = a; bv[c] = b;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(all_done() && !bus.busy) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check_eq({tag, "_finish"}, 32'(n < 2000), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b0, b1, b2, c0, osz, n;
    int exp_o[5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      nterm[i] = 1; abort_at[i] = 0; start_cnt[i] = 0; av[i] = '0; bv[i] = '0; tv_noreq[i] = 0;
    end
    bus.req = '0; bus.term_valid = '0; bus.term_last = '0; bus.a_in = '0; bus.b_in = '0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_grant", 32'(bus.grant), 32'h0);
    check_eq("rst_busy", 32'(bus.busy), 32'h0);
    check_eq("rst_mac_reset", 32'(bus.mac_reset), 32'h1);
    check_eq("rst_mac_start", 32'(bus.mac_start), 32'h0);
    check_eq("rst_res", bus.res, 32'h0);
    check_eq("rst_pulses", 32'({bus.term_ack, bus.res_valid}), 32'h0);
    check_eq("rst_mac_a", 32'(bus.mac_a), 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check_eq("idle_mac_reset", 32'(bus.mac_reset), 32'h0);

    // 1: client0, 3 terms of 0x4000*0x4000
    cfg(0, 3, 16'h4000, 16'h4000);
    b0 = rv_cnt[0]; b1 = ack_cnt[0];
    start_cnt[0]++;
    wait_idle("t1");
    check_eq("t1_res", last_res[0], 32'h3000_0000);
    check_eq("t1_res_valid", 32'(rv_cnt[0] - b0), 32'd1);
    check_eq("t1_term_acks", 32'(ack_cnt[0] - b1), 32'd3);
    repeat (3) @(posedge clk);
    #1 check_eq("t1_res_held", bus.res, 32'h3000_0000);

    // 2: single-term burst on client3
    cfg(3, 1, 16'h7FFF, 16'h251E);
    b0 = rv_cnt[3];
    start_cnt[3]++;
    wait_idle("t2");
    check_eq("t2_res", last_res[3], 32'h128E_DAE2);
    check_eq("t2_res_valid", 32'(rv_cnt[3] - b0), 32'd1);

    // 3: all clients request together, client0 re-requests after its turn
    osz = order_q.size();
    for (int i = 0; i < 4; i++) cfg(i, 1, 16'(i + 1), 16'd2);
    b0 = rv_cnt[0];
    for (int i = 0; i < 4; i++) start_cnt[i]++;
    n = 0;
    while (rv_cnt[0] == b0 && n < 2000) begin @(posedge clk); #1; n++; end
    check_eq("t3_first_served", 32'(rv_cnt[0] - b0), 32'd1);
    start_cnt[0]++;
    wait_idle("t3");
    check_eq("t3_order_len", 32'(order_q.size() - osz), 32'd5);
    for (int k = 0; k < 5; k++)
      if (osz + k < order_q.size())
        check_eq($sformatf("t3_order_%0d", k), 32'(order_q[osz + k]), 32'(exp_o[k]));
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("t3_res_c%0d", i), last_res[i], 32'(2 * (i + 1)));

    // 4: client1 drops req after one of three terms; client2 follows
    abort_at[1] = 1;
    cfg(1, 3, 16'h0100, 16'h0100);
    cfg(2, 2, 16'h0010, 16'h0010);
    b0 = rv_cnt[1]; b1 = ack_cnt[1]; b2 = rv_cnt[2]; c0 = clr_cnt;
    start_cnt[1]++; start_cnt[2]++;
    wait_idle("t4");
    check_eq("t4_no_res_valid_c1", 32'(rv_cnt[1] - b0), 32'd0);
    check_eq("t4_acks_c1", 32'(ack_cnt[1] - b1), 32'd1);
    check_eq("t4_res_valid_c2", 32'(rv_cnt[2] - b2), 32'd1);
    check_eq("t4_res_c2", last_res[2], 32'h0000_0200);
    check_eq("t4_clear_pulses", 32'(clr_cnt - c0), 32'd2);
    abort_at[1] = 0;

    // 5: async reset while waiting for the mac to finish
    cfg(0, 2, 16'd1, 16'd1);
    b0 = rv_cnt[0];
    start_cnt[0]++;
    n = 0;
    while (!(bus.busy && bus.grant != 4'd0 && !bus.mac_start && !bus.mac_ready) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check_eq("t5_reach_wait_high", 32'(n < 2000), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_eq("t5_grant", 32'(bus.grant), 32'h0);
    check_eq("t5_busy", 32'(bus.busy), 32'h0);
    check_eq("t5_mac_start", 32'(bus.mac_start), 32'h0);
    check_eq("t5_mac_reset", 32'(bus.mac_reset), 32'h1);
    check_eq("t5_res", bus.res, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    cfg(1, 2, 16'd3, 16'd5);
    start_cnt[1]++;
    wait_idle("t5");
    check_eq("t5_no_res_valid_c0", 32'(rv_cnt[0] - b0), 32'd0);
    check_eq("t5_res_c1", last_res[1], 32'h0000_001E);

    // 6: client2 presents terms without req while client0 owns the mac
    cfg(0, 2, 16'h0100, 16'h0200);
    av[2] = 16'h7777; bv[2] = 16'h1111; nterm[2] = 1; tv_noreq[2] = 1;
    b2 = ack_cnt[2];
    start_cnt[0]++;
    wait_idle("t6");
    check_eq("t6_no_ack_c2", 32'(ack_cnt[2] - b2), 32'd0);
    check_eq("t6_res_c0", last_res[0], 32'h0004_0000);
    tv_noreq[2] = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
